// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the dual-read-port instruction BRAM between the fetch unit and the debug/loader port.
// Build option IMEM_ARB_PERF_EN adds saturating fetch-deny and debug-force performance counters.

module imem_arbiter_checker (
  input logic clk,
  input logic reset,
  input logic f_gnt,
  input logic d_gnt
);
  // At most one requester may own the memory in any cycle.
  a_single_owner: assert property (@(posedge clk) disable iff (reset) !(f_gnt && d_gnt));
endmodule

module imem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_req,
  input  logic [XLEN-1:0] f_addr0,
  input  logic [XLEN-1:0] f_addr1,
  output logic            f_gnt,
  output logic            f_rvalid,
  output logic [XLEN-1:0] f_rdata0,
  output logic [XLEN-1:0] f_rdata1,
  input  logic            d_halt,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_ren,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr0,
  output logic [XLEN-1:0] m_addr1,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata0,
  input  logic [XLEN-1:0] m_rdata1
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_fetch_deny,
  output logic [15:0]     perf_dbg_force
`endif
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FORCE = 2'd1, ST_HALTED = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_DBG_RD = 2'd2} owner_e;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  state_e          state_r, state_s;
  owner_e          resp_owner_r, resp_owner_s;
  logic [3:0]      starve_cnt_r, starve_cnt_s;
  logic            f_gnt_s, d_gnt_s, d_denied_s;
  logic [XLEN-1:0] f_hold0_r, f_hold1_r, d_hold_r;

  // Arbitration: grants, starvation tracking and next state.
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = 4'd0;
    f_gnt_s      = 1'b0;
    d_gnt_s      = 1'b0;
    d_denied_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        f_gnt_s    = f_req;
        d_gnt_s    = d_req & ~f_req;
        d_denied_s = d_req & f_req;
        // Halt outranks a pending force; the force slot is simply dropped.
        if (d_halt) begin
          state_s = ST_HALTED;
        end else if (d_denied_s && (starve_cnt_r == STARVE_LAST)) begin
          state_s = ST_FORCE;
        end else if (d_denied_s) begin
          starve_cnt_s = starve_cnt_r + 4'd1;
        end else begin
          starve_cnt_s = 4'd0;
        end
      end
      ST_FORCE, ST_HALTED: begin
        d_gnt_s = d_req;
        if (d_halt) begin
          state_s = ST_HALTED;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  assign f_gnt = f_gnt_s & ~reset;
  assign d_gnt = d_gnt_s & ~reset;

  // BRAM drive and owner of next cycle's read data.
  always_comb begin
    m_ren        = 1'b0;
    m_we         = 1'b0;
    m_addr0      = '0;
    m_addr1      = '0;
    m_wdata      = '0;
    resp_owner_s = OWN_NONE;
    if (f_gnt) begin
      m_ren        = 1'b1;
      m_addr0      = f_addr0;
      m_addr1      = f_addr1;
      resp_owner_s = OWN_FETCH;
    end else if (d_gnt && d_we) begin
      m_we    = 1'b1;
      m_addr0 = d_addr;
      m_wdata = d_wdata;
    end else if (d_gnt) begin
      m_ren        = 1'b1;
      m_addr0      = d_addr;
      m_addr1      = d_addr;
      resp_owner_s = OWN_DBG_RD;
    end else begin
      resp_owner_s = OWN_NONE;
    end
  end

  // State, starvation counter, response owner and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_RUN;
      starve_cnt_r <= 4'd0;
      resp_owner_r <= OWN_NONE;
      f_hold0_r    <= '0;
      f_hold1_r    <= '0;
      d_hold_r     <= '0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      resp_owner_r <= resp_owner_s;
      if (resp_owner_r == OWN_FETCH) begin
        f_hold0_r <= m_rdata0;
        f_hold1_r <= m_rdata1;
      end
      if (resp_owner_r == OWN_DBG_RD) begin
        d_hold_r <= m_rdata0;
      end
    end
  end

  // BRAM data is already registered, so it passes straight through in the response cycle.
  assign f_rvalid = (resp_owner_r == OWN_FETCH);
  assign d_rvalid = (resp_owner_r == OWN_DBG_RD);
  assign f_rdata0 = f_rvalid ? m_rdata0 : f_hold0_r;
  assign f_rdata1 = f_rvalid ? m_rdata1 : f_hold1_r;
  assign d_rdata  = d_rvalid ? m_rdata0 : d_hold_r;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_fetch_deny_r;
  logic [15:0] perf_dbg_force_r;

  // Saturating counters for fetch stalls and forced debug slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_deny_r <= 32'd0;
      perf_dbg_force_r  <= 16'd0;
    end else begin
      if (f_req && !f_gnt && (perf_fetch_deny_r != 32'hFFFF_FFFF)) begin
        perf_fetch_deny_r <= perf_fetch_deny_r + 32'd1;
      end
      if ((state_s == ST_FORCE) && (state_r != ST_FORCE) && (perf_dbg_force_r != 16'hFFFF)) begin
        perf_dbg_force_r <= perf_dbg_force_r + 16'd1;
      end
    end
  end

  assign perf_fetch_deny = perf_fetch_deny_r;
  assign perf_dbg_force  = perf_dbg_force_r;
`endif

  imem_arbiter_checker u_checker (
    .clk   (clk),
    .reset (reset),
    .f_gnt (f_gnt),
    .d_gnt (d_gnt)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter/BRAM model.
module tb_imem_arbiter;
  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;

  logic            clk, reset;
  logic            f_req, f_gnt, f_rvalid;
  logic [XLEN-1:0] f_addr0, f_addr1, f_rdata0, f_rdata1;
  logic            d_halt, d_req, d_we, d_gnt, d_rvalid;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            m_ren, m_we;
  logic [XLEN-1:0] m_addr0, m_addr1, m_wdata, m_rdata0, m_rdata1;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]     perf_fetch_deny;
  logic [15:0]     perf_dbg_force;
`endif

  int vectors = 0;
  int miscompares = 0;

  imem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr0(f_addr0), .f_addr1(f_addr1), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata0(f_rdata0), .f_rdata1(f_rdata1),
    .d_halt(d_halt), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ren(m_ren), .m_we(m_we), .m_addr0(m_addr0), .m_addr1(m_addr1), .m_wdata(m_wdata),
    .m_rdata0(m_rdata0), .m_rdata1(m_rdata1)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fetch_deny(perf_fetch_deny), .perf_dbg_force(perf_dbg_force)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: 256 words, 1-cycle registered read, port 0 write-first.
  logic        mem_init;
  logic [31:0] mem [0:255];
  logic [31:0] refmem [0:255];

  function automatic logic [31:0] init_word(input int i);
    if (i < 15) return 32'(i + 1) * 32'h1111_1111;
    else return 32'(i) * 32'h9E37_79B9;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (m_we) begin
      mem[m_addr0[9:2]] <= m_wdata;
      m_rdata0 <= m_wdata;
    end
    if (m_ren) begin
      m_rdata0 <= mem[m_addr0[9:2]];
      m_rdata1 <= mem[m_addr1[9:2]];
    end
  end

  task automatic idle_inputs();
    f_req = 1'b0; f_addr0 = 32'h0; f_addr1 = 32'h0;
    d_halt = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1; mem_init = 1'b1;
    next_cycle(); next_cycle();
    reset = 1'b0; mem_init = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({f_gnt, f_rvalid, d_gnt, d_rvalid, m_ren, m_we} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000000", {f_gnt, f_rvalid, d_gnt, d_rvalid, m_ren, m_we});
    end
    vectors++;
    if ({m_addr0, m_addr1, m_wdata} !== 96'h0) begin
      miscompares++; $display("FAIL reset_maddr: got %h %h %h expected zeros", m_addr0, m_addr1, m_wdata);
    end
    vectors++;
    if ({f_rdata0, f_rdata1, d_rdata} !== 96'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h %h %h expected zeros", f_rdata0, f_rdata1, d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_fetch_only();
    do_reset();
    f_req = 1'b1; f_addr0 = 32'h0; f_addr1 = 32'h4;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      miscompares++; $display("FAIL fetch_gnt: got f=%b d=%b expected f=1 d=0", f_gnt, d_gnt);
    end
    vectors++;
    if ({m_ren, m_we, m_addr0, m_addr1} !== {1'b1, 1'b0, 32'h0, 32'h4}) begin
      miscompares++; $display("FAIL fetch_mem: got ren=%b we=%b a0=%h a1=%h expected 1 0 0 4", m_ren, m_we, m_addr0, m_addr1);
    end
    next_cycle();
    f_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL fetch_rvalid: got f=%b d=%b expected f=1 d=0", f_rvalid, d_rvalid);
    end
    vectors++;
    if (f_rdata0 !== 32'h1111_1111 || f_rdata1 !== 32'h2222_2222) begin
      miscompares++; $display("FAIL fetch_rdata: got %h %h expected 11111111 22222222", f_rdata0, f_rdata1);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (f_rvalid !== 1'b0 || f_rdata0 !== 32'h1111_1111 || f_rdata1 !== 32'h2222_2222) begin
      miscompares++; $display("FAIL fetch_hold: got v=%b %h %h expected 0 11111111 22222222", f_rvalid, f_rdata0, f_rdata1);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    do_reset();
    f_req = 1'b1; f_addr0 = 32'h0; f_addr1 = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++;
      if (d_gnt !== (c == 5) || f_gnt !== (c != 5)) begin
        miscompares++; $display("FAIL starve_gnt cycle %0d: got f=%b d=%b expected f=%b d=%b", c, f_gnt, d_gnt, c != 5, c == 5);
      end
      if (c == 5) begin
        vectors++;
        if ({m_ren, m_we, m_addr0, m_addr1} !== {1'b1, 1'b0, 32'h8, 32'h8}) begin
          miscompares++; $display("FAIL starve_mem: got ren=%b we=%b a0=%h a1=%h expected 1 0 8 8", m_ren, m_we, m_addr0, m_addr1);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h3333_3333) begin
      miscompares++; $display("FAIL starve_rdata: got v=%b %h expected 1 33333333", d_rvalid, d_rdata);
    end
    vectors++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      miscompares++; $display("FAIL starve_resume: got f=%b d=%b expected f=1 d=0", f_gnt, d_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_idle_debug();
    logic [8:0] f_seq, d_exp;
    f_seq = 9'b111110110;
    d_exp = 9'b100001001;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int i = 0; i < 9; i++) begin
      f_req = f_seq[i];
      @(negedge clk);
      vectors++;
      if (d_gnt !== d_exp[i] || f_gnt !== (f_seq[i] & ~d_exp[i])) begin
        miscompares++; $display("FAIL idle_debug step %0d: got f=%b d=%b expected f=%b d=%b", i, f_gnt, d_gnt, f_seq[i] & ~d_exp[i], d_exp[i]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_halt_load();
    do_reset();
    d_halt = 1'b1; f_req = 1'b1; f_addr0 = 32'h0; f_addr1 = 32'h4;
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b0 || d_gnt !== 1'b1) begin
      miscompares++; $display("FAIL halt_wr_gnt: got f=%b d=%b expected f=0 d=1", f_gnt, d_gnt);
    end
    vectors++;
    if ({m_we, m_ren, m_addr0, m_wdata} !== {1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL halt_wr_mem: got we=%b ren=%b a0=%h wd=%h expected 1 0 10 deadbeef", m_we, m_ren, m_addr0, m_wdata);
    end
    next_cycle();
    d_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({f_gnt, d_gnt, m_we, m_ren, d_rvalid} !== 5'b01010 || m_addr0 !== 32'h10 || m_addr1 !== 32'h10) begin
      miscompares++; $display("FAIL halt_rd: got f=%b d=%b we=%b ren=%b rv=%b a0=%h a1=%h expected 0 1 0 1 0 10 10", f_gnt, d_gnt, m_we, m_ren, d_rvalid, m_addr0, m_addr1);
    end
    next_cycle();
    d_req = 1'b0; d_halt = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || f_gnt !== 1'b0) begin
      miscompares++; $display("FAIL halt_raw: got rv=%b %h f=%b expected 1 deadbeef 0", d_rvalid, d_rdata, f_gnt);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1) begin
      miscompares++; $display("FAIL halt_exit: got f_gnt=%b expected 1", f_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    f_req = 1'b1; f_addr0 = 32'h0; f_addr1 = 32'h4;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_gnt: got f_gnt=%b expected 1", f_gnt);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({f_gnt, f_rvalid, d_gnt, d_rvalid, m_ren, m_we} !== 6'b0 || {f_rdata0, f_rdata1, d_rdata} !== 96'h0) begin
      miscompares++; $display("FAIL rstmid_outputs: got flags=%b data=%h %h %h expected zeros", {f_gnt, f_rvalid, d_gnt, d_rvalid, m_ren, m_we}, f_rdata0, f_rdata1, d_rdata);
    end
    next_cycle();
    f_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_run: got f=%b d=%b expected f=1 d=0", f_gnt, d_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    bit          halted, forced, locked, eg, edg, pf, pd;
    int          denied;
    logic [31:0] pf0, pf1, pd0, hf0, hf1, hd, ef0, ef1, ed;
    logic [31:0] ea0, ea1;
    logic [1:0]  erw;
    do_reset();
    for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
    halted = 1'b0; forced = 1'b0; denied = 0; pf = 1'b0; pd = 1'b0;
    pf0 = 32'h0; pf1 = 32'h0; pd0 = 32'h0; hf0 = 32'h0; hf1 = 32'h0; hd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) d_halt = ~d_halt;
      f_req   = ($urandom_range(0, 3) != 0);
      d_req   = 1'($urandom_range(0, 1));
      d_we    = ($urandom_range(0, 3) == 0);
      f_addr0 = $urandom & 32'h3FC;
      f_addr1 = $urandom & 32'h3FC;
      d_addr  = $urandom & 32'h3FC;
      d_wdata = $urandom;
      // Debug owns the memory while halted or in its forced slot; otherwise fetch wins.
      locked = halted || forced;
      eg  = !locked && f_req;
      edg = d_req && (locked || !f_req);
      if (eg) begin erw = 2'b10; ea0 = f_addr0; ea1 = f_addr1; end
      else if (edg && !d_we) begin erw = 2'b10; ea0 = d_addr; ea1 = d_addr; end
      else if (edg) begin erw = 2'b01; ea0 = d_addr; ea1 = 32'h0; end
      else begin erw = 2'b00; ea0 = 32'h0; ea1 = 32'h0; end
      ef0 = pf ? pf0 : hf0;
      ef1 = pf ? pf1 : hf1;
      ed  = pd ? pd0 : hd;
      @(negedge clk);
      vectors++;
      if (f_gnt !== eg || d_gnt !== edg) begin
        miscompares++; $display("FAIL rand_gnt n=%0d: got f=%b d=%b expected f=%b d=%b", n, f_gnt, d_gnt, eg, edg);
      end
      vectors++;
      if ({m_ren, m_we} !== erw || m_addr0 !== ea0 || (erw != 2'b01 && m_addr1 !== ea1) || (erw == 2'b01 && m_wdata !== d_wdata)) begin
        miscompares++; $display("FAIL rand_mem n=%0d: got rw=%b a0=%h a1=%h wd=%h expected rw=%b a0=%h a1=%h wd=%h", n, {m_ren, m_we}, m_addr0, m_addr1, m_wdata, erw, ea0, ea1, d_wdata);
      end
      vectors++;
      if (f_rvalid !== pf || f_rdata0 !== ef0 || f_rdata1 !== ef1) begin
        miscompares++; $display("FAIL rand_fresp n=%0d: got v=%b %h %h expected v=%b %h %h", n, f_rvalid, f_rdata0, f_rdata1, pf, ef0, ef1);
      end
      vectors++;
      if (d_rvalid !== pd || d_rdata !== ed) begin
        miscompares++; $display("FAIL rand_dresp n=%0d: got v=%b %h expected v=%b %h", n, d_rvalid, d_rdata, pd, ed);
      end
      hf0 = ef0; hf1 = ef1; hd = ed;
      pf  = eg;
      pf0 = refmem[f_addr0[9:2]];
      pf1 = refmem[f_addr1[9:2]];
      pd  = edg && !d_we;
      pd0 = refmem[d_addr[9:2]];
      if (edg && d_we) refmem[d_addr[9:2]] = d_wdata;
      if (!locked && d_req && !edg) denied++;
      else denied = 0;
      forced = !d_halt && (denied == STARVE_LIMIT);
      if (forced) denied = 0;
      halted = d_halt;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

`ifdef IMEM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    repeat (10) next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (perf_dbg_force !== 16'd2) begin
      miscompares++; $display("FAIL perf_force: got %0d expected 2", perf_dbg_force);
    end
    vectors++;
    if (perf_fetch_deny !== 32'd2) begin
      miscompares++; $display("FAIL perf_deny: got %0d expected 2", perf_fetch_deny);
    end
    next_cycle();
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    mem_init = 1'b1;
    test_reset();
    test_fetch_only();
    test_starvation();
    test_idle_debug();
    test_halt_load();
    test_reset_mid();
    test_random();
`ifdef IMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
